bus_transfer_controller: RTL and testbench

Sequencer for the shared 16-bit register bus. It accepts move commands ("copy register src, or an immediate, into register dst"), buffers them in a small FIFO and drives the per-register output-enable and set lines. It guarantees one bus driver at a time, a stable bus before and after each set pulse, and a one-cycle idle gap between transfers. It sits between the instruction/control logic and the register bank, which is built from `register` instances sharing one tri-state bus.

---
 rtl/bus_ctrl_pkg.sv | 32 +++
 rtl/bus_transfer_controller_cmd_fifo.sv | 68 ++++++
 rtl/bus_transfer_controller.sv | 145 ++++++++++++++
 tb/tb_bus_transfer_controller.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/bus_ctrl_pkg.sv
// bus_ctrl_pkg
// Definitions shared by the register-bus transfer controller.
//   - ctrl_state_t : sequencer states (IDLE, DRIVE, LATCH, HOLD, DONE)
//   - imm_sel()    : the source index that selects the immediate (= NUM_REGS)
//   - cmd_bits()   : width of one command record, laid out as {src, dst, imm}
//   - cmd_illegal(): legality rule for a move command
package bus_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE,
    DRIVE,
    LATCH,
    HOLD,
    DONE
  } ctrl_state_t;

  // The source index one past the last register selects the immediate.
  function automatic int imm_sel(input int num_regs);
    return num_regs;
  endfunction

  // A command record is {src[sel_w], dst[sel_w], imm[width]}, src in the MSBs.
  function automatic int cmd_bits(input int width, input int sel_w);
    return 2 * sel_w + width;
  endfunction

  // Out-of-range source, out-of-range destination or a self-copy is skipped.
  function automatic logic cmd_illegal(input int src, input int dst, input int num_regs);
    return (src > num_regs) || (dst >= num_regs) || (src == dst);
  endfunction

endpackage

// File: rtl/bus_transfer_controller_cmd_fifo.sv
// cmd_fifo
// Synchronous first-word-fall-through FIFO holding pending bus commands.
// Ports:
//   clk, rst        : clock, synchronous active-high reset (flushes contents)
//   push, wr_data   : write request and data; ignored while full
//   pop, rd_data    : read request; rd_data always shows the head entry
//   full, empty     : occupancy flags derived from the registered count
//   count           : number of stored entries
// DEPTH must be a power of two so the pointers wrap naturally.
module cmd_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           push,
  input  logic [WIDTH-1:0]               wr_data,
  input  logic                           pop,
  output logic [WIDTH-1:0]               rd_data,
  output logic                           full,
  output logic                           empty,
  output logic [$clog2(DEPTH+1)-1:0]     count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign full    = (count == CNT_W'(DEPTH));
  assign empty   = (count == '0);
  assign rd_data = mem[rd_ptr];

  // Storage carries no reset; only the pointers and count define validity.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= wr_data;
    end
  end

  // A simultaneous push and pop leaves the count unchanged.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      if (do_push && !do_pop) begin
        count <= count + 1'b1;
      end else if (!do_push && do_pop) begin
        count <= count - 1'b1;
      end
    end
  end

endmodule

// File: rtl/bus_transfer_controller.sv
// bus_transfer_controller
// Sequences move commands onto the shared register bus so that only one
// driver is active at a time, the bus is stable around each set pulse, and
// every transfer is followed by an idle turnaround cycle.
// Ports:
//   clk, rst                 : clock, synchronous active-high reset
//   cmd_valid / cmd_ready    : command handshake (cmd_ready = FIFO not full)
//   cmd_src, cmd_dst, cmd_imm: command fields; cmd_src == NUM_REGS selects imm
//   reg_en                   : one-hot bus-drive enable of the source register
//   reg_set                  : one-hot load strobe of the destination register
//   imm_en, imm_data         : immediate drive request and its value
//   done, err                : retire pulse; err marks a skipped illegal command
//   busy                     : commands pending or a transfer in progress
module bus_transfer_controller #(
  parameter int  WIDTH      = 16,
  parameter int  NUM_REGS   = 8,
  parameter int  FIFO_DEPTH = 4,
  localparam int SEL_W      = $clog2(NUM_REGS + 1)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic [SEL_W-1:0]    cmd_src,
  input  logic [SEL_W-1:0]    cmd_dst,
  input  logic [WIDTH-1:0]    cmd_imm,
  output logic [NUM_REGS-1:0] reg_en,
  output logic [NUM_REGS-1:0] reg_set,
  output logic                imm_en,
  output logic [WIDTH-1:0]    imm_data,
  output logic                done,
  output logic                err,
  output logic                busy
);

  import bus_ctrl_pkg::*;

  localparam int                  CMD_W       = cmd_bits(WIDTH, SEL_W);
  localparam int                  CNT_W       = $clog2(FIFO_DEPTH + 1);
  localparam logic [SEL_W-1:0]    IMM_SEL     = SEL_W'(imm_sel(NUM_REGS));
  localparam logic [NUM_REGS-1:0] ONE_HOT_LSB = {{(NUM_REGS-1){1'b0}}, 1'b1};

  typedef struct packed {
    logic [SEL_W-1:0] src;
    logic [SEL_W-1:0] dst;
    logic [WIDTH-1:0] imm;
  } cmd_t;

  cmd_t             push_cmd;
  cmd_t             head;
  logic             push;
  logic             fifo_pop;
  logic             fifo_full;
  logic             fifo_empty;
  logic [CNT_W-1:0] fifo_count;
  logic             head_illegal;
  ctrl_state_t      state;
  logic [SEL_W-1:0] cur_dst;

  assign push_cmd     = '{src: cmd_src, dst: cmd_dst, imm: cmd_imm};
  assign cmd_ready    = !fifo_full;
  assign push         = cmd_valid && cmd_ready;
  assign fifo_pop     = ((state == IDLE) || (state == DONE)) && !fifo_empty;
  assign head_illegal = cmd_illegal(int'(head.src), int'(head.dst), NUM_REGS);
  assign busy         = (fifo_count != '0) || (state != IDLE);

  cmd_fifo #(
    .WIDTH (CMD_W),
    .DEPTH (FIFO_DEPTH)
  ) u_cmd_fifo (
    .clk     (clk),
    .rst     (rst),
    .push    (push),
    .wr_data (push_cmd),
    .pop     (fifo_pop),
    .rd_data (head),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .count   (fifo_count)
  );

  // Transfer sequencer. The driver pattern is captured into output registers
  // at the pop edge, so it stays fixed for the whole transfer no matter what
  // the FIFO does afterwards; the set strobe comes from the latched dst.
  // HOLD clears the driver before DONE, which gives the turnaround gap.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      cur_dst  <= '0;
      reg_en   <= '0;
      reg_set  <= '0;
      imm_en   <= 1'b0;
      imm_data <= '0;
      done     <= 1'b0;
      err      <= 1'b0;
    end else begin
      reg_set <= '0;
      done    <= 1'b0;
      err     <= 1'b0;
      case (state)
        IDLE, DONE: begin
          if (!fifo_empty) begin
            cur_dst <= head.dst;
            if (head_illegal) begin
              state <= DONE;
              done  <= 1'b1;
              err   <= 1'b1;
            end else begin
              state <= DRIVE;
              if (head.src == IMM_SEL) begin
                imm_en   <= 1'b1;
                imm_data <= head.imm;
              end else begin
                reg_en <= ONE_HOT_LSB << head.src;
              end
            end
          end else begin
            state <= IDLE;
          end
        end
        DRIVE: begin
          state   <= LATCH;
          reg_set <= ONE_HOT_LSB << cur_dst;
        end
        LATCH: begin
          state <= HOLD;
        end
        HOLD: begin
          state    <= DONE;
          reg_en   <= '0;
          imm_en   <= 1'b0;
          imm_data <= '0;
          done     <= 1'b1;
        end
        default: begin
          state    <= IDLE;
          reg_en   <= '0;
          imm_en   <= 1'b0;
          imm_data <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bus_transfer_controller.sv
// tb_bus_transfer_controller
// Directed bench for bus_transfer_controller. A small register-bank model
// captures the bus whenever reg_set fires, and a negedge monitor checks that
// at most one driver is active and that nothing drives while done is high.
module tb_bus_transfer_controller;

  localparam int WIDTH    = 16;
  localparam int NUM_REGS = 8;
  localparam int SEL_W    = 4;

  logic                clk = 1'b0;
  logic                rst;
  logic                cmd_valid;
  logic                cmd_ready;
  logic [SEL_W-1:0]    cmd_src;
  logic [SEL_W-1:0]    cmd_dst;
  logic [WIDTH-1:0]    cmd_imm;
  logic [NUM_REGS-1:0] reg_en;
  logic [NUM_REGS-1:0] reg_set;
  logic                imm_en;
  logic [WIDTH-1:0]    imm_data;
  logic                done;
  logic                err;
  logic                busy;

  int   total = 0;
  int   bad   = 0;
  logic monitor_on = 1'b0;

  logic [WIDTH-1:0] bank [NUM_REGS];

  bus_transfer_controller #(
    .WIDTH      (WIDTH),
    .NUM_REGS   (NUM_REGS),
    .FIFO_DEPTH (4)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_src   (cmd_src),
    .cmd_dst   (cmd_dst),
    .cmd_imm   (cmd_imm),
    .reg_en    (reg_en),
    .reg_set   (reg_set),
    .imm_en    (imm_en),
    .imm_data  (imm_data),
    .done      (done),
    .err       (err),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  // Value currently on the shared bus as seen by the register bank.
  function automatic logic [WIDTH-1:0] bus_value();
    logic [WIDTH-1:0] v;
    v = '0;
    if (imm_en) v = imm_data;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (reg_en[i]) v = bank[i];
    end
    return v;
  endfunction

  // Register bank model: register i starts at 16'h1000 + i*16'h0111.
  always @(posedge clk) begin
    for (int i = 0; i < NUM_REGS; i++) begin
      if (rst) bank[i] <= 16'h1000 + 16'(i) * 16'h0111;
      else if (reg_set[i]) bank[i] <= bus_value();
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    total++;
    assert (observed === expected)
    else begin
      bad++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Bus-contention and turnaround monitor.
  always @(negedge clk) begin
    if (monitor_on) begin
      checkOutput("one_driver", 32'(($countones(reg_en) + int'(imm_en)) <= 1), 32'd1);
      if (done) checkOutput("done_no_drive", {reg_en, imm_en}, 32'd0);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic valid, input logic [SEL_W-1:0] src,
                               input logic [SEL_W-1:0] dst, input logic [WIDTH-1:0] imm);
    cmd_valid = valid;
    cmd_src   = src;
    cmd_dst   = dst;
    cmd_imm   = imm;
  endtask

  task automatic checkQuiet(input string tag);
    checkOutput(tag, {reg_en, reg_set, imm_en}, 32'd0);
  endtask

  logic [SEL_W-1:0] bb_src [5];
  logic [SEL_W-1:0] bb_dst [5];

  initial begin
    bb_src = '{4'd7, 4'd6, 4'd5, 4'd4, 4'd1};
    bb_dst = '{4'd1, 4'd2, 4'd3, 4'd7, 4'd0};

    $display("[TB] reset");
    rst = 1'b1;
    applyStimulus(1'b0, '0, '0, '0);
    tick();
    tick();
    checkOutput("rst_ready", cmd_ready, 1);
    checkOutput("rst_en", reg_en, 0);
    checkOutput("rst_set", reg_set, 0);
    checkOutput("rst_imm_en", imm_en, 0);
    checkOutput("rst_imm_data", imm_data, 0);
    checkOutput("rst_done", done, 0);
    checkOutput("rst_err", err, 0);
    checkOutput("rst_busy", busy, 0);
    rst = 1'b0;
    monitor_on = 1'b1;
    tick();

    $display("[TB] register move r2 -> r5");
    applyStimulus(1'b1, 4'd2, 4'd5, 16'h0);
    checkOutput("t1_ready", cmd_ready, 1);
    checkOutput("t1_c0_busy", busy, 0);
    tick();
    applyStimulus(1'b0, '0, '0, '0);
    checkOutput("t1_c1_busy", busy, 1);
    checkOutput("t1_c1_en", reg_en, 0);
    tick();
    checkOutput("t1_c2_en", reg_en, 8'h04);
    checkOutput("t1_c2_set", reg_set, 0);
    tick();
    checkOutput("t1_c3_en", reg_en, 8'h04);
    checkOutput("t1_c3_set", reg_set, 8'h20);
    tick();
    checkOutput("t1_c4_en", reg_en, 8'h04);
    checkOutput("t1_c4_set", reg_set, 0);
    checkOutput("t1_c4_done", done, 0);
    tick();
    checkOutput("t1_c5_done", done, 1);
    checkOutput("t1_c5_err", err, 0);
    checkOutput("t1_c5_en", reg_en, 0);
    checkOutput("t1_r5", bank[5], 16'h1222);
    tick();
    checkOutput("t1_c6_done", done, 0);
    checkOutput("t1_c6_busy", busy, 0);

    $display("[TB] immediate move BEEF -> r0");
    applyStimulus(1'b1, 4'd8, 4'd0, 16'hBEEF);
    tick();
    applyStimulus(1'b0, '0, '0, '0);
    tick();
    checkOutput("t2_c2_imm_en", imm_en, 1);
    checkOutput("t2_c2_imm_data", imm_data, 16'hBEEF);
    checkOutput("t2_c2_en", reg_en, 0);
    tick();
    checkOutput("t2_c3_set", reg_set, 8'h01);
    checkOutput("t2_c3_imm_en", imm_en, 1);
    tick();
    checkOutput("t2_c4_imm_data", imm_data, 16'hBEEF);
    tick();
    checkOutput("t2_c5_done", done, 1);
    checkOutput("t2_c5_imm_en", imm_en, 0);
    checkOutput("t2_c5_imm_data", imm_data, 0);
    checkOutput("t2_r0", bank[0], 16'hBEEF);
    tick();

    $display("[TB] five back-to-back commands");
    for (int k = 0; k < 5; k++) begin
      applyStimulus(1'b1, bb_src[k], bb_dst[k], 16'h0);
      checkOutput("bb_ready", cmd_ready, 1);
      tick();
    end
    applyStimulus(1'b0, '0, '0, '0);
    checkOutput("bb_full", cmd_ready, 0);
    for (int c = 5; c <= 22; c++) begin
      checkOutput("bb_done", done, (((c - 5) % 4 == 0) && (c <= 21)) ? 32'd1 : 32'd0);
      checkOutput("bb_err", err, 0);
      if (c == 6) checkOutput("bb_ready_back", cmd_ready, 1);
      tick();
    end
    checkOutput("bb_r1", bank[1], 16'h1777);
    checkOutput("bb_r2", bank[2], 16'h1666);
    checkOutput("bb_r3", bank[3], 16'h1222);
    checkOutput("bb_r7", bank[7], 16'h1444);
    checkOutput("bb_r0", bank[0], 16'h1777);
    checkOutput("bb_busy", busy, 0);

    $display("[TB] illegal commands");
    applyStimulus(1'b1, 4'd3, 4'd3, 16'h0);
    tick();
    applyStimulus(1'b1, 4'd1, 4'd9, 16'h0);
    checkOutput("il_c1_done", done, 0);
    checkQuiet("il_c1_quiet");
    tick();
    applyStimulus(1'b1, 4'd12, 4'd0, 16'h1234);
    checkOutput("il_c2_done", done, 1);
    checkOutput("il_c2_err", err, 1);
    checkQuiet("il_c2_quiet");
    tick();
    applyStimulus(1'b0, '0, '0, '0);
    checkOutput("il_c3_done", done, 1);
    checkOutput("il_c3_err", err, 1);
    checkQuiet("il_c3_quiet");
    tick();
    checkOutput("il_c4_done", done, 1);
    checkOutput("il_c4_err", err, 1);
    checkQuiet("il_c4_quiet");
    tick();
    checkOutput("il_c5_done", done, 0);
    checkOutput("il_c5_err", err, 0);
    checkOutput("il_c5_busy", busy, 0);
    checkOutput("il_r0", bank[0], 16'h1777);

    $display("[TB] reset during LATCH");
    applyStimulus(1'b1, 4'd2, 4'd6, 16'h0);
    tick();
    applyStimulus(1'b1, 4'd3, 4'd5, 16'h0);
    tick();
    applyStimulus(1'b1, 4'd4, 4'd5, 16'h0);
    checkOutput("mr_c2_en", reg_en, 8'h04);
    tick();
    applyStimulus(1'b0, '0, '0, '0);
    checkOutput("mr_c3_set", reg_set, 8'h40);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checkOutput("mr_en", reg_en, 0);
    checkOutput("mr_set", reg_set, 0);
    checkOutput("mr_imm_en", imm_en, 0);
    checkOutput("mr_done", done, 0);
    checkOutput("mr_ready", cmd_ready, 1);
    checkOutput("mr_busy", busy, 0);
    for (int c = 0; c < 6; c++) begin
      tick();
      checkOutput("mr_no_done", done, 0);
      checkOutput("mr_no_en", reg_en, 0);
      checkOutput("mr_idle", busy, 0);
    end

    monitor_on = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
